// File: rtl/uart_serial_rx_pkg.sv
// Shared UART constants and state encoding, common to the receive and transmit paths.
package uart_serial_rx_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    // Parity bit a transmitter would append to the given byte.
    function automatic logic expected_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Multi-flop synchroniser for one asynchronous input; resets to 1 (idle line level).
module uart_bit_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic ret,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_serial_rx.sv
// UART receiver: oversampled 11-bit frame (start, 8 data LSB-first, parity, stop)
// delivered through a level-valid / read-acknowledge output register.
module uart_serial_rx
    import uart_serial_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 ret,
    input  logic                 rx,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);
    localparam logic             ODD_BIT  = PARITY_ODD[0];

    logic                 rxs;
    uart_state_e          state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 sample;

    uart_bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .ret(ret),
        .d  (rx),
        .q  (rxs)
    );

    // Mid-bit sample point for DATA, PARITY and STOP.
    assign sample = (cnt == CNT_LAST);

    // Frame FSM, bit counters and the output holding register.
    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            state      <= StIdle;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // A read consumes the held byte; a completing frame below overrides this.
            if (rd && valid) begin
                valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= StStart;
                        busy  <= 1'b1;
                    end
                end

                StStart: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rxs) begin
                            // Low pulse shorter than half a bit: not a real start bit.
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            bit_idx <= '0;
                            state   <= StData;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StData: begin
                    if (sample) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state <= StParity;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StParity: begin
                    if (sample) begin
                        cnt     <= '0;
                        par_bad <= (rxs != expected_parity(shreg, ODD_BIT));
                        state   <= StStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StStop: begin
                    if (sample) begin
                        cnt        <= '0;
                        data_out   <= shreg;
                        parity_err <= par_bad;
                        frame_err  <= ~rxs;
                        valid      <= 1'b1;
                        // Previous byte lost only if it was neither read earlier nor now.
                        if (valid && !rd) begin
                            overrun <= 1'b1;
                        end
                        // Leave at mid-stop so an immediately following start is caught.
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_serial_rx.sv
// Self-checking bench for uart_serial_rx: directed scenarios plus random frames
// compared against a frame-level model of the output register.
module tb_uart_serial_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned ODD = 0;

    logic       clk;
    logic       ret;
    logic       rx;
    logic       rd;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Frame-level model of what the consumer should see.
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovr;

    uart_serial_rx #(
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (ODD),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .ret       (ret),
        .rx        (rx),
        .rd        (rd),
        .data_out  (data_out),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check({tag, ".data"}, 32'(data_out), 32'(m_data));
        check({tag, ".perr"}, 32'(parity_err), 32'(m_perr));
        check({tag, ".ferr"}, 32'(frame_err), 32'(m_ferr));
        check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    function automatic void model_clear();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endfunction

    function automatic void model_complete(input logic [7:0] d, input logic bad_par,
                                           input logic stop, input logic rd_same);
        if (m_valid && !rd_same) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = d;
        m_perr  = bad_par;
        m_ferr  = ~stop;
    endfunction

    // Drives the first nbits bits of a frame, CPB cycles each, starting at a negedge;
    // then idles the line high for gap cycles.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input int nbits, input int gap);
        logic [10:0] bits;
        bits = {stop, ((^d) ^ 1'(ODD)) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (m_valid) m_valid = 1'b0;
    endtask

    task automatic do_reset();
        ret = 1'b0;
        #1;
        model_clear();
        check("reset.valid", 32'(valid), 32'd0);
        check("reset.data", 32'(data_out), 32'd0);
        check("reset.ovr", 32'(overrun), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        @(negedge clk);
        ret = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd_byte;
        logic       rbad;
        logic       rstop;

        ret = 1'b0;
        rx  = 1'b1;
        rd  = 1'b0;
        model_clear();
        #1;
        check_all("por");
        repeat (2) @(negedge clk);
        ret = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5 clean, with completion timed at 171 cycles after the start edge.
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 11, 10);
            begin
                repeat (169) @(negedge clk);
                check("lat.before", 32'(valid), 32'd0);
                repeat (3) @(negedge clk);
                check("lat.after", 32'(valid), 32'd1);
            end
        join
        model_complete(8'hA5, 1'b0, 1'b1, 1'b0);
        check_all("a5");
        pulse_rd();
        check_all("a5.read");
        pulse_rd();
        check_all("a5.read_idle");

        // Parity error.
        send_frame(8'h3C, 1'b1, 1'b1, 11, 10);
        model_complete(8'h3C, 1'b1, 1'b1, 1'b0);
        check_all("3c.perr");
        pulse_rd();

        // Framing error, then a clean byte.
        send_frame(8'h81, 1'b0, 1'b0, 11, 12);
        model_complete(8'h81, 1'b0, 1'b0, 1'b0);
        check_all("81.ferr");
        pulse_rd();
        send_frame(8'h55, 1'b0, 1'b1, 11, 10);
        model_complete(8'h55, 1'b0, 1'b1, 1'b0);
        check_all("55.clean");
        pulse_rd();

        // Short glitch: false start.
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        check("glitch.busy", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        check_all("glitch.idle");

        // Back-to-back without reading: overrun.
        do_reset();
        send_frame(8'h11, 1'b0, 1'b1, 11, 0);
        model_complete(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 11, 10);
        model_complete(8'h22, 1'b0, 1'b1, 1'b0);
        check_all("ovr.set");

        // Same again, but read in the very cycle the second frame completes.
        do_reset();
        send_frame(8'h11, 1'b0, 1'b1, 11, 0);
        model_complete(8'h11, 1'b0, 1'b1, 1'b0);
        fork
            send_frame(8'h22, 1'b0, 1'b1, 11, 10);
            begin
                repeat (170) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        model_complete(8'h22, 1'b0, 1'b1, 1'b1);
        check_all("ovr.rd_same");

        // Reset during data bit 4 of 0xF0, then 0x0F.
        send_frame(8'hF0, 1'b0, 1'b1, 5, 8);
        check("mid.busy", 32'(busy), 32'd1);
        do_reset();
        check_all("mid.after");
        repeat (10) @(negedge clk);
        send_frame(8'h0F, 1'b0, 1'b1, 11, 10);
        model_complete(8'h0F, 1'b0, 1'b1, 1'b0);
        check_all("0f");
        pulse_rd();

        // Random frames against the model.
        for (int n = 0; n < 8; n++) begin
            rd_byte = 8'($urandom);
            rbad    = ($urandom_range(0, 3) == 0);
            rstop   = ($urandom_range(0, 3) != 0);
            send_frame(rd_byte, rbad, rstop, 11, 12 + int'($urandom_range(0, 4)));
            model_complete(rd_byte, rbad, rstop, 1'b0);
            check_all("rand");
            if ($urandom_range(0, 1) == 1) begin
                pulse_rd();
                check_all("rand.read");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
